// File: rtl/xs3_serial_alu_seq.sv
// Digit-serial excess-3 add/subtract sequencer: one XS3 digit per clock through a shared digit adder.
// Optional operand code checking is enabled with the XS3_SEQ_CHECK_EN macro.
module xs3_serial_alu_seq #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] result,
  output logic                sign,
  output logic                carry,
  output logic                busy,
  output logic                err
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);
  localparam logic [W-1:0]  XS3_ZERO = {DIGITS{4'h3}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic           op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic           cin_q, cin_d;
  logic           sign_q, sign_d, carry_q, carry_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, busy_q, busy_d;

  logic [3:0] add_x, add_y, add_digit;
  logic [4:0] add_raw;
  logic       add_cout;

`ifdef XS3_SEQ_CHECK_EN
  logic bad_q, bad_d, err_q, err_d;

  function automatic logic all_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] < 4'h3 || v[4*i +: 4] > 4'hC) ok = 1'b0;
    end
    return ok;
  endfunction
`endif

  // Shared digit adder: operands always come from the low digit of the shift registers
  always_comb begin
    add_x = a_q[3:0];
    add_y = op_q ? ~b_q[3:0] : b_q[3:0];
    if (state_q == S_FIX) begin
      add_x = ~res_q[3:0];
      add_y = 4'h3;
    end
    add_raw = {1'b0, add_x} + {1'b0, add_y} + {4'b0000, cin_q};
    if (add_raw[4]) begin
      add_digit = add_raw[3:0] + 4'd3;
      add_cout  = 1'b1;
    end else begin
      add_digit = add_raw[3:0] - 4'd3;
      add_cout  = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    idx_d       = idx_q;
    cin_d       = cin_q;
    sign_d      = sign_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef XS3_SEQ_CHECK_EN
    bad_d       = bad_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d       = op;
          a_d        = a;
          b_d        = b;
          idx_d      = '0;
          cin_d      = op;
          sign_d     = 1'b0;
          carry_d    = 1'b0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_CALC;
`ifdef XS3_SEQ_CHECK_EN
          bad_d      = !(all_legal(a) && all_legal(b));
`endif
        end
      end
      S_CALC: begin
        // Results enter at the top so digit 0 lands at the bottom after DIGITS shifts
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = {add_digit, res_q[W-1:4]};
        cin_d = add_cout;
        idx_d = idx_q + CW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (!op_q || add_cout) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            out_valid_d = 1'b1;
            carry_d     = !op_q && add_cout;
          end else begin
            state_d = S_FIX;
            cin_d   = 1'b1;
          end
        end
`ifdef XS3_SEQ_CHECK_EN
        if (bad_q) begin
          state_d     = S_DONE;
          res_d       = XS3_ZERO;
          sign_d      = 1'b0;
          carry_d     = 1'b0;
          idx_d       = '0;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          err_d       = 1'b1;
        end
`endif
      end
      S_FIX: begin
        res_d = {add_digit, res_q[W-1:4]};
        cin_d = add_cout;
        idx_d = idx_q + CW'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = S_DONE;
          sign_d      = 1'b1;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
`ifdef XS3_SEQ_CHECK_EN
          err_d       = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      cin_q       <= 1'b0;
      sign_q      <= 1'b0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef XS3_SEQ_CHECK_EN
      bad_q       <= 1'b0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      idx_q       <= idx_d;
      cin_q       <= cin_d;
      sign_q      <= sign_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef XS3_SEQ_CHECK_EN
      bad_q       <= bad_d;
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign sign      = sign_q;
  assign carry     = carry_q;
  assign busy      = busy_q;
`ifdef XS3_SEQ_CHECK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_xs3_serial_alu_seq.sv
// Self-checking bench for xs3_serial_alu_seq (DIGITS = 4): decimal reference model plus per-cycle compare.
// Honours XS3_SEQ_CHECK_EN when the same macro is defined for the build.
module tb_xs3_serial_alu_seq;
  localparam int DIG = 4;
  localparam int W   = 4 * DIG;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, op, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic         sign, carry, busy, err;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  xs3_serial_alu_seq #(.DIGITS(DIG)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .sign(sign), .carry(carry), .busy(busy), .err(err)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         sign;
    logic         carry;
    logic         err;
    logic         nochk;
    logic [7:0]   lat;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint xs3_to_int(input logic [W-1:0] v);
    longint n = 0;
    longint p = 1;
    for (int i = 0; i < DIG; i++) begin
      n += (longint'(v[4*i +: 4]) - 3) * p;
      p *= 10;
    end
    return n;
  endfunction

  function automatic logic [W-1:0] int_to_xs3(input longint n);
    logic [W-1:0] v = '0;
    longint t = n;
    for (int i = 0; i < DIG; i++) begin
      v[4*i +: 4] = 4'(t % 10 + 3);
      t /= 10;
    end
    return v;
  endfunction

  function automatic logic legal(input logic [W-1:0] v);
    for (int i = 0; i < DIG; i++)
      if (v[4*i +: 4] < 4'h3 || v[4*i +: 4] > 4'hC) return 1'b0;
    return 1'b1;
  endfunction

  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e = '0;
    longint va = xs3_to_int(x);
    longint vb = xs3_to_int(y);
    longint m = 10000;
    e.lat = 8'(DIG);
    if (!(legal(x) && legal(y))) begin
`ifdef XS3_SEQ_CHECK_EN
      e.res = {DIG{4'h3}};
      e.err = 1'b1;
      e.lat = 8'd1;
      return e;
`else
      e.nochk = 1'b1;
`endif
    end
    if (!o) begin
      e.res   = int_to_xs3((va + vb) % m);
      e.carry = (va + vb) >= m;
    end else if (va >= vb) begin
      e.res = int_to_xs3(va - vb);
    end else begin
      e.res  = int_to_xs3(vb - va);
      e.sign = 1'b1;
      e.lat  = 8'(2 * DIG);
    end
    return e;
  endfunction

  // Reference timing: 0 = idle, 1 = computing, 2 = result held
  int   m_phase = 0;
  int   m_cnt = 0;
  exp_t m_exp = '0;
  exp_t m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_cnt   <= 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_tmp    = model(op, a, b);
          m_exp   <= m_tmp;
          m_cnt   <= int'(m_tmp.lat);
          m_phase <= 1;
        end
        1: if (m_cnt == 1) m_phase <= 2; else m_cnt <= m_cnt - 1;
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("busy", busy, m_phase == 1);
      if (m_phase == 2) begin
        chk("err", err, m_exp.err);
        if (!m_exp.nochk) begin
          chk("result", result, m_exp.res);
          chk("sign", sign, m_exp.sign);
          chk("carry", carry, m_exp.carry);
        end
      end else begin
        chk("err_idle", err, 0);
      end
    end
  end

  task automatic run_op(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb, input int hold,
                        output logic [W-1:0] r, output logic s, output logic c, output logic e,
                        output int lat);
    int n = 0;
    @(negedge clk);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    if (!out_valid) chk("done_timeout", 0, 1);
    r = result; s = sign; c = carry; e = err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, r);
      chk("hold_sign", sign, s);
      chk("hold_in_ready", in_ready, 0);
    end
    $display("op=%0d a=%h b=%h -> result=%h sign=%0d carry=%0d err=%0d lat=%0d", o, aa, bb, r, s, c, e, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
  endtask

  function automatic logic [W-1:0] rand_xs3();
    logic [W-1:0] v;
    for (int i = 0; i < DIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9) + 3);
    return v;
  endfunction

  initial begin
    logic [W-1:0] r, ra, rb;
    logic s, c, e, ro;
    int   l;
    exp_t pe;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_sign", sign, 0);
    chk("rst_carry", carry, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    started = 1;

    pe = model(1'b0, 16'h4567, 16'h89AB);
    chk("model_add", pe.res, 16'h9C45);
    pe = model(1'b1, 16'h4567, 16'h8333);
    chk("model_sub_neg", {pe.res, pe.sign, pe.lat}, {16'h6A99, 1'b1, 8'd8});

    run_op(1'b0, 16'h4567, 16'h89AB, 0, r, s, c, e, l);
    chk("t1", {r, s, c, 8'(l)}, {16'h9C45, 1'b0, 1'b0, 8'd4});
    run_op(1'b0, 16'hCCCC, 16'h3334, 0, r, s, c, e, l);
    chk("t2", {r, s, c}, {16'h3333, 1'b0, 1'b1});
    run_op(1'b1, 16'h8333, 16'h4567, 0, r, s, c, e, l);
    chk("t3", {r, s, c, 8'(l)}, {16'h6A99, 1'b0, 1'b0, 8'd4});
    run_op(1'b1, 16'h4567, 16'h8333, 0, r, s, c, e, l);
    chk("t4_neg", {r, s, c, 8'(l)}, {16'h6A99, 1'b1, 1'b0, 8'd8});
    run_op(1'b1, 16'h3375, 16'h3375, 0, r, s, c, e, l);
    chk("t4_eq", {r, s}, {16'h3333, 1'b0});
    run_op(1'b1, 16'h4567, 16'h8333, 5, r, s, c, e, l);
    chk("t5_hold", {r, s}, {16'h6A99, 1'b1});

    // Abort during the second CALC cycle
    @(negedge clk);
    op = 1'b0; a = 16'h4567; b = 16'h89AB; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk); #1 rst_n = 1'b1;
    run_op(1'b0, 16'hCCCC, 16'h3334, 0, r, s, c, e, l);
    chk("after_abort", {r, c, 8'(l)}, {16'h3333, 1'b1, 8'd4});

    run_op(1'b0, 16'h45F7, 16'h3333, 0, r, s, c, e, l);
`ifdef XS3_SEQ_CHECK_EN
    chk("t6_chk", {r, s, c, e, 8'(l)}, {16'h3333, 1'b0, 1'b0, 1'b1, 8'd1});
`else
    chk("t6_nochk", {e, 8'(l)}, {1'b0, 8'd4});
`endif

    for (int i = 0; i < 40; i++) begin
      ra = rand_xs3();
      rb = ($urandom_range(0, 7) == 0) ? ra : rand_xs3();
      ro = 1'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 2), r, s, c, e, l);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
